uart_tx_arbiter: RTL and testbench

Shares one UART_TX instance among `NUM_REQ` byte-stream requesters using round-robin arbitration with packet locking. A granted requester owns the transmitter until it sends a byte flagged last, or until it stalls past a timeout. Each packet may be prefixed with a header byte that identifies the requester. The block sits between the on-chip message sources and UART_TX, driving UART_TX's `i_TX_DV`/`i_TX_Byte` and consuming its `o_TX_Active`/`o_TX_Done`.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encodings,
// header tag and requester-id width.
package uart_pkg;

  // Requester ids are carried in the low nibble of the header byte.
  localparam int ID_W = 4;

  // Upper nibble of every header byte.
  localparam logic [3:0] HDR_TAG = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HDR       = 3'd1,
    ST_WAIT_HDR  = 3'd2,
    ST_DATA      = 3'd3,
    ST_WAIT_DATA = 3'd4
  } state_t;

  // Header byte identifying the owner of the packet that follows.
  function automatic logic [7:0] hdr_byte(input logic [ID_W-1:0] id);
    return {HDR_TAG, id};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART_TX side signals of the transmit arbiter.
// master: requesters plus UART_TX (the environment); slave: the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   i_Req_DV;
  logic [8*NUM_REQ-1:0] i_Req_Byte;
  logic [NUM_REQ-1:0]   i_Req_Last;
  logic [NUM_REQ-1:0]   o_Req_Ready;
  logic [NUM_REQ-1:0]   o_Grant;
  logic                 o_Abort;
  logic                 o_Busy;
  logic                 o_TX_DV;
  logic [7:0]           o_TX_Byte;
  logic                 i_TX_Active;
  logic                 i_TX_Done;

  modport master (
    output i_Req_DV, i_Req_Byte, i_Req_Last, i_TX_Active, i_TX_Done,
    input  o_Req_Ready, o_Grant, o_Abort, o_Busy, o_TX_DV, o_TX_Byte
  );

  modport slave (
    input  i_Req_DV, i_Req_Byte, i_Req_Last, i_TX_Active, i_TX_Done,
    output o_Req_Ready, o_Grant, o_Abort, o_Busy, o_TX_DV, o_TX_Byte
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick. The search starts one past the last
// owner and ascends with wrap, so the previous owner has lowest priority.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  logic found;
  logic hit;

  // Walk priority positions in order; the first requesting slot wins.
  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    hit   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        hit      = !found && req[k] && (k == ((int'(last) + 1 + i) % NUM_REQ));
        grant[k] = grant[k] | hit;
        id       = hit ? ID_W'(k) : id;
        found    = found | hit;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART_TX among NUM_REQ byte-stream requesters. A winner keeps
// the transmitter until its last-flagged byte completes or it stalls past
// TIMEOUT_CLKS; each packet is optionally preceded by an id header byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int HEADER_EN    = 1,
  parameter int TIMEOUT_CLKS = 8680
) (
  input logic              i_Clock,
  input logic              i_Rst_L,
  uart_tx_arbiter_if.slave bus
);

  // Counter is sized to hold TIMEOUT_CLKS; a zero timeout keeps one bit.
  localparam int CNT_W = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;
  // Abort fires on the stall cycle that brings the count to TIMEOUT_CLKS.
  localparam logic [CNT_W-1:0] STALL_LIMIT =
    CNT_W'((TIMEOUT_CLKS > 0) ? (TIMEOUT_CLKS - 1) : 0);
  // Out of reset the pointer sits on the top requester so requester 0 leads.
  localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NUM_REQ - 1);

  state_t             state;
  logic [ID_W-1:0]    last_id;
  logic [ID_W-1:0]    gnt_id;
  logic [CNT_W-1:0]   stall_cnt;
  logic               pkt_last;

  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] grant;
  logic               abort;
  logic               busy;
  logic               tx_dv;
  logic [7:0]         tx_byte;

  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_id;
  logic               arb_any;

  logic               sel_dv;
  logic               sel_last;
  logic [7:0]         sel_byte;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req   (bus.i_Req_DV),
    .last  (last_id),
    .grant (arb_grant),
    .id    (arb_id),
    .any   (arb_any)
  );

  // Mux the owner's valid, last flag and byte using the one-hot grant.
  always_comb begin
    sel_dv   = 1'b0;
    sel_last = 1'b0;
    sel_byte = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_dv   = sel_dv   | (grant[k] & bus.i_Req_DV[k]);
      sel_last = sel_last | (grant[k] & bus.i_Req_Last[k]);
      sel_byte = sel_byte | ({8{grant[k]}} & bus.i_Req_Byte[8*k +: 8]);
    end
  end

  // Arbitration FSM with all outputs registered; pulses default low.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state     <= ST_IDLE;
      last_id   <= LAST_INIT;
      gnt_id    <= '0;
      stall_cnt <= '0;
      pkt_last  <= 1'b0;
      req_ready <= '0;
      grant     <= '0;
      abort     <= 1'b0;
      busy      <= 1'b0;
      tx_dv     <= 1'b0;
      tx_byte   <= 8'h00;
    end else begin
      tx_dv     <= 1'b0;
      req_ready <= '0;
      abort     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_any && !bus.i_TX_Active) begin
            grant     <= arb_grant;
            gnt_id    <= arb_id;
            busy      <= 1'b1;
            stall_cnt <= '0;
            state     <= (HEADER_EN != 0) ? ST_HDR : ST_DATA;
          end
        end
        ST_HDR: begin
          // Hold off while the transmitter is still shifting.
          if (!bus.i_TX_Active) begin
            tx_dv   <= 1'b1;
            tx_byte <= hdr_byte(gnt_id);
            state   <= ST_WAIT_HDR;
          end
        end
        ST_WAIT_HDR: begin
          if (bus.i_TX_Done) begin
            stall_cnt <= '0;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (sel_dv && !bus.i_TX_Active) begin
            tx_dv     <= 1'b1;
            tx_byte   <= sel_byte;
            req_ready <= grant;
            pkt_last  <= sel_last;
            state     <= ST_WAIT_DATA;
          end else if ((TIMEOUT_CLKS != 0) && (stall_cnt == STALL_LIMIT)) begin
            // Revoke the grant without sending anything; owner goes to back.
            abort   <= 1'b1;
            grant   <= '0;
            busy    <= 1'b0;
            last_id <= gnt_id;
            state   <= ST_IDLE;
          end else if (TIMEOUT_CLKS != 0) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_DATA: begin
          if (bus.i_TX_Done) begin
            if (pkt_last) begin
              last_id <= gnt_id;
              grant   <= '0;
              busy    <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              stall_cnt <= '0;
              state     <= ST_DATA;
            end
          end
        end
        default: begin
          grant     <= '0;
          busy      <= 1'b0;
          stall_cnt <= '0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_Req_Ready = req_ready;
  assign bus.o_Grant     = grant;
  assign bus.o_Abort     = abort;
  assign bus.o_Busy      = busy;
  assign bus.o_TX_DV     = tx_dv;
  assign bus.o_TX_Byte   = tx_byte;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural UART_TX
// (4 clocks per bit, 10-bit frame). Tests push expected grants, bytes,
// ready pulses and aborts; a negedge monitor pops and compares.
module tb_uart_tx_arbiter;

  localparam int CLKS_PER_BIT = 4;
  localparam int FRAME_CLKS   = 10 * CLKS_PER_BIT;

  typedef struct packed {
    logic       last;
    logic [7:0] b;
  } item_t;

  typedef struct {
    logic [3:0] owner;
    int         lat;
  } abort_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ      (4),
    .HEADER_EN    (1),
    .TIMEOUT_CLKS (10)
  ) dut (
    .i_Clock (clk),
    .i_Rst_L (rst_n),
    .bus     (bus)
  );

  item_t      rq [4][$];
  logic [3:0] gate = 4'hF;

  logic [3:0] exp_grant_q [$];
  logic [7:0] exp_tx_q    [$];
  logic [3:0] exp_rdy_q   [$];
  abort_t     exp_abort_q [$];

  int         compared      = 0;
  int         mismatched    = 0;
  int         cyc           = 0;
  int         last_done_cyc = 0;
  int         grant_cyc     = 0;
  logic       first_tx      = 1'b0;
  logic [3:0] prev_grant    = 4'h0;
  int         tx_cnt        = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    compared++;
    mismatched++;
    $display("FAIL %s: unexpected event with value 0x%0h (t=%0t)", name, act, $time);
  endtask

  // Behavioural UART_TX: accepts o_TX_DV when idle, busy for one frame, then Done.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.i_TX_Active <= 1'b0;
      bus.i_TX_Done   <= 1'b0;
      tx_cnt          <= 0;
    end else begin
      bus.i_TX_Done <= 1'b0;
      if (!bus.i_TX_Active) begin
        if (bus.o_TX_DV) begin
          bus.i_TX_Active <= 1'b1;
          tx_cnt          <= 0;
        end
      end else if (tx_cnt == FRAME_CLKS - 1) begin
        bus.i_TX_Active <= 1'b0;
        bus.i_TX_Done   <= 1'b1;
      end else begin
        tx_cnt <= tx_cnt + 1;
      end
    end
  end

  // Requester models: present queue head, advance on o_Req_Ready.
  initial begin
    bus.i_Req_DV   = 4'h0;
    bus.i_Req_Byte = 32'h0;
    bus.i_Req_Last = 4'h0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
        if (bus.o_Req_Ready[k] && rq[k].size() > 0) void'(rq[k].pop_front());
        if (gate[k] && rq[k].size() > 0) begin
          bus.i_Req_DV[k]          = 1'b1;
          bus.i_Req_Byte[8*k +: 8] = rq[k][0].b;
          bus.i_Req_Last[k]        = rq[k][0].last;
        end else begin
          bus.i_Req_DV[k]          = 1'b0;
          bus.i_Req_Byte[8*k +: 8] = 8'h00;
          bus.i_Req_Last[k]        = 1'b0;
        end
      end
    end
  end

  // Monitor: compare every DUT event against the scoreboard queues.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (bus.i_TX_Done) last_done_cyc = cyc;
      if (bus.o_Grant != prev_grant && bus.o_Grant != 4'h0) begin
        if (exp_grant_q.size() == 0) unexpected("grant", 32'(bus.o_Grant));
        else chk("grant", 32'(bus.o_Grant), 32'(exp_grant_q.pop_front()));
        grant_cyc = cyc;
        first_tx  = 1'b1;
      end
      if (bus.o_TX_DV) begin
        if (exp_tx_q.size() == 0) unexpected("tx_byte", 32'(bus.o_TX_Byte));
        else chk("tx_byte", 32'(bus.o_TX_Byte), 32'(exp_tx_q.pop_front()));
        if (first_tx) chk("hdr_latency", 32'(cyc - grant_cyc), 32'd1);
        else chk("byte_latency", 32'(cyc - last_done_cyc), 32'd2);
        first_tx = 1'b0;
        chk("busy_during_tx", 32'(bus.o_Busy), 32'd1);
        chk("dv_abort_excl", 32'(bus.o_Abort), 32'd0);
      end
      if (bus.o_Req_Ready != 4'h0) begin
        if (exp_rdy_q.size() == 0) unexpected("req_ready", 32'(bus.o_Req_Ready));
        else chk("req_ready", 32'(bus.o_Req_Ready), 32'(exp_rdy_q.pop_front()));
        chk("ready_with_dv", 32'(bus.o_TX_DV), 32'd1);
      end
      if (bus.o_Abort) begin
        if (exp_abort_q.size() == 0) unexpected("abort", 32'(prev_grant));
        else begin
          abort_t e;
          e = exp_abort_q.pop_front();
          chk("abort_owner", 32'(prev_grant), 32'(e.owner));
          chk("abort_latency", 32'(cyc - last_done_cyc), 32'(e.lat));
        end
        chk("abort_grant_clr", 32'(bus.o_Grant), 32'd0);
        chk("abort_busy_clr", 32'(bus.o_Busy), 32'd0);
      end
    end
    prev_grant = bus.o_Grant;
  end

  task automatic send(input int k, input logic [7:0] b, input logic last);
    rq[k].push_back({last, b});
  endtask

  task automatic exp_pkt(input logic [3:0] g, input logic [7:0] hdr);
    exp_grant_q.push_back(g);
    exp_tx_q.push_back(hdr);
  endtask

  task automatic exp_byte(input logic [3:0] g, input logic [7:0] b);
    exp_tx_q.push_back(b);
    exp_rdy_q.push_back(g);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"}, 32'(bus.o_Req_Ready), 32'd0);
    chk({tag, "_grant"}, 32'(bus.o_Grant), 32'd0);
    chk({tag, "_abort"}, 32'(bus.o_Abort), 32'd0);
    chk({tag, "_busy"},  32'(bus.o_Busy), 32'd0);
    chk({tag, "_tx_dv"}, 32'(bus.o_TX_DV), 32'd0);
    chk({tag, "_tx_byte"}, 32'(bus.o_TX_Byte), 32'd0);
  endtask

  task automatic flush();
    for (int k = 0; k < 4; k++) rq[k].delete();
    exp_grant_q.delete();
    exp_tx_q.delete();
    exp_rdy_q.delete();
    exp_abort_q.delete();
    first_tx = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    int left;
    n = 0;
    while (!(exp_grant_q.size() == 0 && exp_tx_q.size() == 0 && exp_rdy_q.size() == 0 &&
             exp_abort_q.size() == 0 && bus.o_Busy == 1'b0 && bus.o_Grant == 4'h0) &&
           n < 3000) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (n >= 3000) begin
      mismatched++;
      $display("FAIL %s: idle not reached, pending grants=%0d bytes=%0d readies=%0d aborts=%0d",
               name, exp_grant_q.size(), exp_tx_q.size(), exp_rdy_q.size(), exp_abort_q.size());
    end
    left = 0;
    for (int k = 0; k < 4; k++) left += rq[k].size();
    chk({name, "_drained"}, 32'(left), 32'd0);
  endtask

  task automatic wait_ready(input int k, input string name);
    int n;
    n = 0;
    while (!bus.o_Req_Ready[k] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (n >= 1000) begin
      mismatched++;
      $display("FAIL %s: o_Req_Ready[%0d] never pulsed", name, k);
    end
  endtask

  task automatic wait_grant(input logic [3:0] g, input string name);
    int n;
    n = 0;
    while (bus.o_Grant != g && n < 1000) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (n >= 1000) begin
      mismatched++;
      $display("FAIL %s: grant 0x%0h never seen", name, g);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single packet from requester 2 with header.
    exp_pkt(4'b0100, 8'hA2);
    exp_byte(4'b0100, 8'h55);
    exp_byte(4'b0100, 8'h33);
    send(2, 8'h55, 1'b0);
    send(2, 8'h33, 1'b1);
    wait_idle("single");

    // Simultaneous requests right after reset: order 0, 1, 3.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("reset2");
    flush();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_pkt(4'b0001, 8'hA0);
    exp_byte(4'b0001, 8'h11);
    exp_pkt(4'b0010, 8'hA1);
    exp_byte(4'b0010, 8'h22);
    exp_pkt(4'b1000, 8'hA3);
    exp_byte(4'b1000, 8'h44);
    send(0, 8'h11, 1'b1);
    send(1, 8'h22, 1'b1);
    send(3, 8'h44, 1'b1);
    wait_idle("simul");

    // Fairness wrap: requester 3 served, then 0 beats 3.
    exp_pkt(4'b1000, 8'hA3);
    exp_byte(4'b1000, 8'h66);
    send(3, 8'h66, 1'b1);
    wait_idle("wrap_a");
    exp_pkt(4'b0001, 8'hA0);
    exp_byte(4'b0001, 8'h77);
    exp_pkt(4'b1000, 8'hA3);
    exp_byte(4'b1000, 8'h88);
    send(0, 8'h77, 1'b1);
    send(3, 8'h88, 1'b1);
    wait_idle("wrap_b");

    // Packet lock: requester 0 arrives mid-packet and must wait.
    exp_pkt(4'b0010, 8'hA1);
    exp_byte(4'b0010, 8'hC1);
    exp_byte(4'b0010, 8'hC2);
    exp_byte(4'b0010, 8'hC3);
    exp_pkt(4'b0001, 8'hA0);
    exp_byte(4'b0001, 8'hD0);
    send(1, 8'hC1, 1'b0);
    send(1, 8'hC2, 1'b0);
    send(1, 8'hC3, 1'b1);
    wait_ready(1, "lock_first_byte");
    send(0, 8'hD0, 1'b1);
    wait_idle("lock");

    // Timeout: requester 2 stalls after its header; 3 then 0 follow.
    exp_pkt(4'b0100, 8'hA2);
    exp_abort_q.push_back('{owner: 4'b0100, lat: 11});
    exp_pkt(4'b1000, 8'hA3);
    exp_byte(4'b1000, 8'hF3);
    exp_pkt(4'b0001, 8'hA0);
    exp_byte(4'b0001, 8'hF0);
    send(2, 8'hEE, 1'b1);
    send(3, 8'hF3, 1'b1);
    send(0, 8'hF0, 1'b1);
    wait_grant(4'b0100, "timeout_grant");
    gate[2] = 1'b0;
    while (rq[3].size() != 0 || rq[0].size() != 0 || exp_tx_q.size() != 0) begin
      if (cyc > 90000) break;
      @(negedge clk);
    end
    rq[2].delete();
    gate[2] = 1'b1;
    wait_idle("timeout");

    // Reset during the third data bit of a data byte.
    exp_pkt(4'b0100, 8'hA2);
    exp_byte(4'b0100, 8'h5A);
    send(2, 8'h5A, 1'b0);
    send(2, 8'h3C, 1'b1);
    wait_ready(2, "midbyte_ready");
    @(posedge clk);
    repeat (13) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midbyte");
    chk("midbyte_tx_byte_left", 32'(exp_tx_q.size()), 32'd0);
    flush();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_pkt(4'b0001, 8'hA0);
    exp_byte(4'b0001, 8'h0F);
    exp_pkt(4'b0100, 8'hA2);
    exp_byte(4'b0100, 8'h2F);
    send(0, 8'h0F, 1'b1);
    send(2, 8'h2F, 1'b1);
    wait_idle("after_reset");

    // Quiet period to catch stray events.
    repeat (60) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
